// File: rtl/pucch_ncs_hop_if.sv
// Output beat stream of pucch_ncs_hop: symbol index, n_cs and alpha index
// under a valid/ready handshake.
interface pucch_ncs_hop_if;
   logic       o_valid;
   logic       i_ready;
   logic [3:0] o_sym;
   logic [7:0] o_ncs;
   logic [3:0] o_cs;
   logic       o_last;

   modport master (output o_valid, o_sym, o_ncs, o_cs, o_last, input i_ready);
   modport slave  (input o_valid, o_sym, o_ncs, o_cs, o_last, output i_ready);
endinterface

// File: rtl/pucch_ncs_hop.sv
// PUCCH cyclic-shift hopping: skips earlier-slot Gold words from c_seq_gen,
// captures the per-symbol n_cs bytes of n_slot and streams (l, n_cs, alpha).
module pucch_ncs_hop #(
   parameter int unsigned NSYMB     = 14,
   parameter int unsigned NSLOT_MAX = 159
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_start,
   input  logic [9:0]      i_nid,
   input  logic [7:0]      i_nslot,
   input  logic [3:0]      i_m0,
   input  logic [3:0]      i_mcs,
   output logic            o_prbs_load,
   output logic            o_prbs_en,
   output logic [30:0]     o_prbs_init,
   input  logic [7:0]      i_prbs_word,
   input  logic            i_prbs_valid,
   output logic            o_busy,
   output logic            o_err,
   pucch_ncs_hop_if.master out_if
);
   typedef enum logic [2:0] {IDLE, LOAD, SKIP, COLLECT, OUT} state_t;

   localparam logic [15:0] NSYMB16   = 16'(NSYMB);
   localparam logic [15:0] LAST_WORD = 16'(NSYMB - 1);
   localparam logic [3:0]  LAST_SYM  = 4'(NSYMB - 1);

   state_t      state, state_d;
   logic [9:0]  nid_q;
   logic [7:0]  nslot_q;
   logic [3:0]  m0_q, mcs_q;
   logic        armed_q;
   logic [15:0] word_cnt;
   logic [15:0] skip_words;
   logic [7:0]  ncs_rf [NSYMB];
   logic [3:0]  sym_ptr;
   logic        valid_q, last_q;
   logic [3:0]  sym_q, cs_q;
   logic [7:0]  ncs_q;
   logic        accept, reject, load_beat;
   logic [8:0]  cs_sum, cs_mod;

   // armed_q blocks a start on the first edge after reset release
   assign accept     = (state == IDLE) && armed_q && i_start && (i_nslot <= 8'(NSLOT_MAX));
   assign reject     = (state == IDLE) && armed_q && i_start && (i_nslot >  8'(NSLOT_MAX));
   assign skip_words = NSYMB16 * {8'd0, nslot_q};
   assign cs_sum     = {5'd0, m0_q} + {5'd0, mcs_q} + {1'b0, ncs_rf[sym_ptr]};
   assign cs_mod     = cs_sum % 9'd12;

   assign o_busy         = (state != IDLE);
   assign o_prbs_init    = {21'd0, nid_q};
   assign out_if.o_valid = valid_q;
   assign out_if.o_sym   = sym_q;
   assign out_if.o_ncs   = ncs_q;
   assign out_if.o_cs    = cs_q;
   assign out_if.o_last  = last_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d     = state;
      o_prbs_load = 1'b0;
      o_prbs_en   = 1'b0;
      load_beat   = 1'b0;
      unique case (state)
         IDLE: if (accept) state_d = LOAD;
         LOAD: begin
            o_prbs_load = 1'b1;
            o_prbs_en   = 1'b1;
            state_d     = (skip_words == 16'd0) ? COLLECT : SKIP;
         end
         SKIP: begin
            o_prbs_en = 1'b1;
            if (i_prbs_valid && (word_cnt == skip_words - 16'd1)) state_d = COLLECT;
         end
         COLLECT: begin
            o_prbs_en = 1'b1;
            if (i_prbs_valid && (word_cnt == LAST_WORD)) state_d = OUT;
         end
         OUT: begin
            if (!valid_q) load_beat = 1'b1;
            else if (out_if.i_ready) begin
               if (last_q) state_d = IDLE;
               else        load_beat = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed_q  <= 1'b0;
         o_err    <= 1'b0;
         nid_q    <= '0;
         nslot_q  <= '0;
         m0_q     <= '0;
         mcs_q    <= '0;
         word_cnt <= '0;
         sym_ptr  <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         sym_q    <= '0;
         ncs_q    <= '0;
         cs_q     <= '0;
         for (int unsigned i = 0; i < NSYMB; i++) ncs_rf[i] <= '0;
      end else begin
         armed_q <= 1'b1;
         o_err   <= reject;
         if (accept) begin
            nid_q   <= i_nid;
            nslot_q <= i_nslot;
            m0_q    <= i_m0;
            mcs_q   <= i_mcs;
         end
         // one counter serves both phases: it restarts at the SKIP->COLLECT boundary
         if (state == LOAD) word_cnt <= '0;
         else if (((state == SKIP) || (state == COLLECT)) && i_prbs_valid) begin
            if ((state == SKIP) && (state_d == COLLECT)) word_cnt <= '0;
            else                                         word_cnt <= word_cnt + 16'd1;
            if (state == COLLECT) ncs_rf[word_cnt[3:0]] <= i_prbs_word;
         end
         if (state != OUT) sym_ptr <= '0;
         if (load_beat) begin
            valid_q <= 1'b1;
            sym_q   <= sym_ptr;
            ncs_q   <= ncs_rf[sym_ptr];
            cs_q    <= cs_mod[3:0];
            last_q  <= (sym_ptr == LAST_SYM);
            sym_ptr <= sym_ptr + 4'd1;
         end else if ((state == OUT) && valid_q && out_if.i_ready && last_q) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_pucch_ncs_hop.sv
// Directed bench for pucch_ncs_hop with a behavioural Gold-sequence upstream
// (or ramp / constant stubs) and a table of request vectors.
`timescale 1ns/1ps
module tb_pucch_ncs_hop;
   localparam int unsigned NSYMB   = 14;
   localparam int          GEN_LAT = 3;

   typedef struct {
      int unsigned src;     // 0 Gold, 1 ramp k mod 256, 2 constant 255
      int unsigned nid;
      int unsigned nslot;
      int unsigned m0;
      int unsigned mcs;
      bit          bp;      // ready pattern 1,0,0,1 plus valid gaps
      int          cs_first;
      int          cs_last;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic [9:0]  i_nid = '0;
   logic [7:0]  i_nslot = '0;
   logic [3:0]  i_m0 = '0, i_mcs = '0;
   logic        o_prbs_load, o_prbs_en, o_busy, o_err;
   logic [30:0] o_prbs_init;
   logic [7:0]  i_prbs_word;
   logic        i_prbs_valid;

   int          n_checks = 0, n_fail = 0;
   int unsigned src_mode = 0;
   bit          gap_en = 1'b0;
   int          words_used = 0;
   vec_t        vecs[6];

   always #5 clk = ~clk;

   pucch_ncs_hop_if out_if();

   pucch_ncs_hop #(.NSYMB(NSYMB), .NSLOT_MAX(159)) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_nid(i_nid), .i_nslot(i_nslot),
      .i_m0(i_m0), .i_mcs(i_mcs), .o_prbs_load(o_prbs_load), .o_prbs_en(o_prbs_en),
      .o_prbs_init(o_prbs_init), .i_prbs_word(i_prbs_word), .i_prbs_valid(i_prbs_valid),
      .o_busy(o_busy), .o_err(o_err), .out_if(out_if)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // state = {x2, x1}; bit 0 of each holds x(n)
   function automatic logic [61:0] gstep(input logic [61:0] s);
      logic [30:0] a, b;
      a = s[30:0];
      b = s[61:31];
      a = {a[3] ^ a[0], a[30:1]};
      b = {b[3] ^ b[2] ^ b[1] ^ b[0], b[30:1]};
      return {b, a};
   endfunction

   function automatic logic [7:0] exp_word(input int unsigned src, input int unsigned nid,
                                           input int unsigned k);
      logic [61:0] s;
      logic [31:0] kk;
      logic [7:0]  w;
      kk = k;
      if (src == 1) return kk[7:0];
      if (src == 2) return 8'hFF;
      s = {21'd0, nid[9:0], 31'd1};
      for (int unsigned i = 0; i < 1600 + 8 * k; i++) s = gstep(s);
      for (int m = 0; m < 8; m++) begin
         w[m] = s[0] ^ s[31];
         s = gstep(s);
      end
      return w;
   endfunction

   initial begin : upstream
      logic [61:0] s;
      logic [7:0]  w;
      int          lat, cyc, k;
      i_prbs_valid = 1'b0;
      i_prbs_word  = '0;
      s = '0; lat = 0; cyc = 0; k = 0;
      forever begin
         @(posedge clk); #1;
         cyc++;
         if (!rst_n) begin
            i_prbs_valid = 1'b0;
            lat = 0;
         end else if (o_prbs_load) begin
            s = {o_prbs_init, 31'd1};
            for (int i = 0; i < 1600; i++) s = gstep(s);
            k = 0; words_used = 0; lat = GEN_LAT;
            i_prbs_valid = 1'b0;
         end else if (o_prbs_en && lat > 0) begin
            lat--;
            i_prbs_valid = 1'b0;
         end else if (o_prbs_en && !(gap_en && (cyc % 3 == 2))) begin
            for (int m = 0; m < 8; m++) begin
               w[m] = s[0] ^ s[31];
               s = gstep(s);
            end
            if (src_mode == 1)      i_prbs_word = 8'(k);
            else if (src_mode == 2) i_prbs_word = 8'hFF;
            else                    i_prbs_word = w;
            k++;
            words_used++;
            i_prbs_valid = 1'b1;
         end else begin
            i_prbs_valid = 1'b0;
         end
      end
   end

   task automatic start_req(input vec_t v);
      src_mode = v.src;
      gap_en   = v.bp;
      i_nid    = 10'(v.nid);
      i_nslot  = 8'(v.nslot);
      i_m0     = 4'(v.m0);
      i_mcs    = 4'(v.mcs);
      i_start  = 1'b1;
      @(posedge clk); #1;
      i_start  = 1'b0;
      check("busy_after_start", 32'(o_busy), 32'd1);
      check("load_after_start", 32'(o_prbs_load), 32'd1);
   endtask

   task automatic collect(input vec_t v, input bit chk_lat);
      logic [7:0]  en[NSYMB];
      logic [17:0] held;
      bit          hold, rdy;
      int          beats, cyc, first_cyc, exp_cs;
      beats = 0; cyc = 0; first_cyc = -1; hold = 1'b0; held = '0;
      for (int unsigned l = 0; l < NSYMB; l++) en[l] = exp_word(v.src, v.nid, NSYMB * v.nslot + l);
      while (beats < NSYMB && cyc < 6000) begin
         if (hold)
            check("stable_under_bp", 32'({out_if.o_valid, out_if.o_sym, out_if.o_ncs,
                                          out_if.o_cs, out_if.o_last}), 32'(held));
         rdy = v.bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         out_if.i_ready = rdy;
         hold = 1'b0;
         if (out_if.o_valid) begin
            if (first_cyc < 0) first_cyc = cyc;
            if (rdy) begin
               exp_cs = (v.m0 + v.mcs + int'(en[beats])) % 12;
               check("sym", 32'(out_if.o_sym), 32'(beats));
               check("ncs", 32'(out_if.o_ncs), 32'(en[beats]));
               check("cs", 32'(out_if.o_cs), 32'(exp_cs));
               check("last", 32'(out_if.o_last), 32'(beats == NSYMB - 1));
               if (beats == 0 && v.cs_first >= 0) check("cs_first", 32'(out_if.o_cs), 32'(v.cs_first));
               if (beats == NSYMB - 1 && v.cs_last >= 0) check("cs_last", 32'(out_if.o_cs), 32'(v.cs_last));
               beats++;
            end else begin
               hold = 1'b1;
               held = {out_if.o_valid, out_if.o_sym, out_if.o_ncs, out_if.o_cs, out_if.o_last};
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      out_if.i_ready = 1'b1;
      check("beats_before_timeout", 32'(beats), 32'(NSYMB));
      check("busy_after_last", 32'(o_busy), 32'd0);
      check("valid_after_last", 32'(out_if.o_valid), 32'd0);
      check("words_consumed", 32'(words_used), 32'(NSYMB * (v.nslot + 1)));
      if (chk_lat) check("first_valid_latency", 32'(first_cyc), 32'(2 + GEN_LAT + NSYMB * (v.nslot + 1)));
   endtask

   task automatic check_all_zero(input string name);
      check(name, 32'({o_prbs_load, o_prbs_en, o_busy, o_err, out_if.o_valid, out_if.o_last,
                       out_if.o_sym, out_if.o_ncs, out_if.o_cs}), 32'd0);
      check({name, "_init"}, 32'(o_prbs_init), 32'd0);
   endtask

   initial begin : watchdog
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int waited;
      vecs[0] = '{0, 512, 3,  0,  0, 1'b0, -1, -1};
      vecs[1] = '{0, 100, 2,  0,  0, 1'b0, -1, -1};
      vecs[2] = '{0, 512, 0,  0,  0, 1'b0, -1, -1};
      vecs[3] = '{1,   0, 0, 11, 11, 1'b0, 10, 11};
      vecs[4] = '{2,   0, 1, 11, 11, 1'b0,  1,  1};
      vecs[5] = '{1,   7, 2,  3,  5, 1'b1,  0,  1};
      out_if.i_ready = 1'b1;

      // reset values, then a start held across reset release
      i_start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset_outputs");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      check("start_at_reset_release_busy", 32'(o_busy), 32'd0);
      check("start_at_reset_release_load", 32'(o_prbs_load), 32'd0);
      @(posedge clk); #1;

      // rejected slot number
      i_nslot = 8'd160;
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      check("err_pulse", 32'(o_err), 32'd1);
      check("err_busy", 32'(o_busy), 32'd0);
      check("err_no_load", 32'(o_prbs_load), 32'd0);
      @(posedge clk); #1;
      check("err_one_cycle", 32'(o_err), 32'd0);
      check("err_still_idle", 32'(o_busy), 32'd0);

      // table vectors, issued back to back
      for (int i = 0; i < 6; i++) begin
         start_req(vecs[i]);
         collect(vecs[i], !vecs[i].bp);
      end

      // start while busy is ignored
      start_req(vecs[0]);
      repeat (3) @(posedge clk);
      #1;
      i_nid = 10'd77;
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      check("busy_start_nid_kept", 32'(o_prbs_init), 32'd512);
      check("busy_start_no_err", 32'(o_err), 32'd0);
      collect(vecs[0], 1'b0);

      // reset in COLLECT, then the golden request again
      start_req(vecs[0]);
      waited = 0;
      while (words_used < 45 && waited < 500) begin
         @(posedge clk); #1;
         waited++;
      end
      check("reach_collect", 32'(words_used >= 45), 32'd1);
      rst_n = 1'b0;
      #1;
      check_all_zero("mid_reset_outputs");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      start_req(vecs[0]);
      collect(vecs[0], 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/pucch_ncs_hop.md
# pucch_ncs_hop

Consumes the 8-bit-per-cycle Gold-sequence words of `c_seq_gen` (nGenBit = 8) and turns them into the PUCCH cyclic-shift hopping values of TS 38.211 §6.3.2.2.2. Per request it loads the generator with c_init = n_ID, discards the words of earlier slots, and captures the 14 (or 12) per-symbol n_cs bytes of slot n_slot. It then streams (l, n_cs, alpha index) to the PUCCH sequence stage over a valid/ready handshake.

## Interface
- `NSYMB`, 14: symbols per slot (14 normal CP, 12 extended CP).
- `NSLOT_MAX`, 159: largest legal n_slot.
- `clk`  in  1  clock, all logic rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `i_start`  in  1  one-cycle request pulse; ignored while `o_busy`.
- `i_nid`  in  10  n_ID (hopping ID), sampled on accepted `i_start`.
- `i_nslot`  in  8  slot number, sampled on accepted `i_start`.
- `i_m0`  in  4  initial cyclic shift, 0..11, sampled on accepted `i_start`.
- `i_mcs`  in  4  m_cs, 0..11, sampled on accepted `i_start`.
- `o_prbs_load`  out  1  load strobe to `c_seq_gen.i_load`.
- `o_prbs_en`  out  1  enable to `c_seq_gen.i_en`.
- `o_prbs_init`  out  31  `{21'b0, nid}` to `c_seq_gen.i_init`.
- `i_prbs_word`  in  8  `c_seq_gen.o_seq_bit`; bit m = c(8k+m).
- `i_prbs_valid`  in  1  `c_seq_gen.o_valid`.
- `o_valid`  out  1  output beat valid.
- `i_ready`  in  1  downstream accepts beat.
- `o_sym`  out  4  symbol index l.
- `o_ncs`  out  8  n_cs(n_slot, l).
- `o_cs`  out  4  (m0 + mcs + n_cs) mod 12.
- `o_last`  out  1  high on beat l = NSYMB-1.
- `o_busy`  out  1  high from accepted start through final handshake.
- `o_err`  out  1  one-cycle pulse on rejected request.

## Operation
- FSM states: IDLE, LOAD, SKIP, COLLECT, OUT.
- IDLE: on `i_start` with `i_nslot` ≤ NSLOT_MAX, register the inputs and go to LOAD. If `i_nslot` > NSLOT_MAX, pulse `o_err` and stay in IDLE.
- LOAD, one cycle: `o_prbs_load`=1, `o_prbs_en`=1, `o_prbs_init` = registered nid. Clear the word counter and go to SKIP.
- `o_prbs_en` stays 1 through SKIP and COLLECT and is 0 in OUT and IDLE. Words are counted only on `i_prbs_valid`; gaps in valid are tolerated.
- SKIP: discard words 0 .. NSYMB·n_slot−1 (16-bit counter; max 2226). When the skip count is 0 (n_slot = 0), go straight to COLLECT.
- COLLECT: store NSYMB valid words in order into an `ncs[0..NSYMB-1]` register file. After the last word, go to OUT with the symbol pointer at 0.
- OUT: present entry l with `o_cs` computed from the registered m0, mcs and ncs[l].
  - Widths: the 9-bit sum (maximum 22+255=277) is reduced mod 12 by compare-and-subtract or a constant-divide. `o_cs` is registered together with `o_ncs`.
  - l advances on `o_valid & i_ready`. The handshake on l = NSYMB-1 returns the FSM to IDLE.
- `o_valid` is asserted only in OUT. Once asserted, the beat's data holds until it is accepted.
- Reset mid-operation: all state returns to IDLE immediately; the generator is reloaded on the next request.

## Timing
- Reset values: every output is 0. `o_prbs_init` = 0, FSM in IDLE.
- Accepted `i_start` at edge T gives `o_prbs_load` high during cycle T+1 and `o_busy` high from T+1.
- With continuous `i_prbs_valid`, the first `o_valid` appears 1 cycle after the last collected word (register-file write, then an output register stage).
- Total time from start to first `o_valid` is 2 + gen_latency + NSYMB·(n_slot+1) cycles, where gen_latency is the generator's load-to-valid delay.
- With `i_ready` held high, one beat per cycle: NSYMB beats in NSYMB cycles.
- `o_busy` drops in the cycle after the last handshake. A new `i_start` is accepted in that same cycle (back-to-back requests allowed).
- `i_start` coincident with reset deassertion is ignored.

## Test plan
- Golden vectors: real `c_seq_gen`, nid=512, nslot=3, m0=0, mcs=0, `i_ready`=1.
  - Required: exactly 42 words skipped, 14 beats with `o_ncs` matching `ncs_c_seq_gen_nid512_nslot3.txt`, and `o_last` on l=13.
  - Repeat for (100,2) and (512,0); the (512,0) case has no SKIP cycles.
- Modulo arithmetic: stub upstream drives word k = k mod 256 every cycle, nslot=0, m0=11, mcs=11.
  - Required: `o_ncs`=l and `o_cs`=(22+l) mod 12, i.e. 10,11,0,1,…,11.
- Modulo upper bound: stub drives 255 on every word, m0=11, mcs=11. Required: `o_cs`=277 mod 12 = 1 on all beats.
- Backpressure: `i_ready` toggles 1,0,0,1 repeating, plus valid gaps on `i_prbs_valid` every 3rd cycle.
  - Required: beats are never dropped or duplicated, and data is stable while `o_valid & !i_ready`.
- Errors and busy: nslot=160 gives an `o_err` pulse, `o_busy`=0 and no `o_prbs_load`. `i_start` while busy is ignored and the stored nid is unchanged.
- Reset mid-operation: assert `rst_n`=0 during COLLECT. Required: all outputs 0 immediately. A following request with nid=512, nslot=3 reproduces the golden sequence.
